// File: rtl/memory_access_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, write-strobe constants
// and the store-side lane helpers. MEM_ALIGN_CHECK_EN enables misalignment trapping.
package memory_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    // Strobes shift out of the top lane for a half at offset 3; that lane is dropped.
    function automatic logic [3:0] calc_wstrb(input logic is_store,
                                              input logic [1:0] size,
                                              input logic [1:0] lo);
        logic [3:0] s;
        if (!is_store) begin
            s = WSTRB_NONE;
        end else begin
            case (size)
                SIZE_BYTE: s = WSTRB_BYTE << lo;
                SIZE_HALF: s = WSTRB_HALF << lo;
                default:   s = WSTRB_WORD;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size,
                                               input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {4{data[7:0]}};
            SIZE_HALF: d = {2{data[15:0]}};
            default:   d = data;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-lane selector: picks the byte/half addressed by addr_lo out of
// the returned word and sign- or zero-extends it.
module load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Halves use only addr_lo[1]; a stray addr_lo[0] is ignored here.
    always_comb begin
        byte_sel = lane[addr_lo];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: result = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
            SIZE_HALF: result = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: forwards ALU ops to WB and runs loads/stores over the data-SRAM
// request/addr_ok/data_ok handshake. MEM_ALIGN_CHECK_EN adds the mem_misaligned trap.
module memory_access
    import memory_access_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_load_unsigned,
    input  logic [31:0] ex_inst,
    output logic        ex_ready,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_waddr,
    output logic        wb_reg_write,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        mem_misaligned,
`endif
    output logic [31:0] wb_inst
);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        wr_reg, wr_next;
    logic [4:0]  waddr_reg, waddr_next;
    logic        reg_write_reg, reg_write_next;
    logic        mem_to_reg_reg, mem_to_reg_next;
    logic [1:0]  size_reg, size_next;
    logic        unsigned_reg, unsigned_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] buf_result_reg, buf_result_next;

    logic        wb_valid_reg, wb_valid_next;
    logic [31:0] wb_result_reg, wb_result_next;
    logic [4:0]  wb_waddr_reg, wb_waddr_next;
    logic        wb_reg_write_reg, wb_reg_write_next;
    logic [31:0] wb_inst_reg, wb_inst_next;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned_reg, misaligned_next;
`endif

    logic        ex_is_mem;
    logic        accept;
    logic        complete;
    logic [31:0] load_result;
    logic [31:0] mem_result;

    assign ex_is_mem = ex_mem_read | ex_mem_write;
    assign ex_ready  = (state_reg == ST_IDLE) && !stall;
    assign accept    = ex_valid && ex_ready;
    assign stall_req = (state_reg != ST_IDLE) || (ex_valid && ex_is_mem);

    load_align u_load_align (
        .rdata         (data_rdata),
        .addr_lo       (addr_reg[1:0]),
        .size          (size_reg),
        .load_unsigned (unsigned_reg),
        .result        (load_result)
    );

    assign mem_result = mem_to_reg_reg ? load_result : addr_reg;

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        wstrb_next        = wstrb_reg;
        wdata_next        = wdata_reg;
        wr_next           = wr_reg;
        waddr_next        = waddr_reg;
        reg_write_next    = reg_write_reg;
        mem_to_reg_next   = mem_to_reg_reg;
        size_next         = size_reg;
        unsigned_next     = unsigned_reg;
        inst_next         = inst_reg;
        buf_result_next   = buf_result_reg;
        wb_valid_next     = wb_valid_reg;
        wb_result_next    = wb_result_reg;
        wb_waddr_next     = wb_waddr_reg;
        wb_reg_write_next = wb_reg_write_reg;
        wb_inst_next      = wb_inst_reg;
        complete          = 1'b0;
        // wb_valid is a pulse, but the whole WB register freezes while stalled.
        if (!stall) begin
            wb_valid_next = 1'b0;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_next = misaligned_reg;
        if (!stall) begin
            misaligned_next = 1'b0;
        end
`endif

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (ex_is_mem) begin
`ifdef MEM_ALIGN_CHECK_EN
                        if (is_misaligned(ex_size, ex_alu_result[1:0])) begin
                            wb_valid_next     = 1'b1;
                            wb_result_next    = ex_alu_result;
                            wb_waddr_next     = ex_waddr;
                            wb_reg_write_next = 1'b0;
                            wb_inst_next      = ex_inst;
                            misaligned_next   = 1'b1;
                        end else
`endif
                        begin
                            addr_next       = ex_alu_result;
                            wstrb_next      = calc_wstrb(ex_mem_write, ex_size, ex_alu_result[1:0]);
                            wdata_next      = calc_wdata(ex_size, ex_store_data);
                            wr_next         = ex_mem_write;
                            waddr_next      = ex_waddr;
                            reg_write_next  = ex_reg_write;
                            mem_to_reg_next = ex_mem_to_reg;
                            size_next       = ex_size;
                            unsigned_next   = ex_load_unsigned;
                            inst_next       = ex_inst;
                            state_next      = ST_REQ;
                        end
                    end else begin
                        wb_valid_next     = 1'b1;
                        wb_result_next    = ex_alu_result;
                        wb_waddr_next     = ex_waddr;
                        wb_reg_write_next = ex_reg_write;
                        wb_inst_next      = ex_inst;
                    end
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        complete = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    complete = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    wb_valid_next     = 1'b1;
                    wb_result_next    = buf_result_reg;
                    wb_waddr_next     = waddr_reg;
                    wb_reg_write_next = reg_write_reg;
                    wb_inst_next      = inst_reg;
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The SRAM will not repeat data_ok, so a stalled completion is parked in the buffer.
        if (complete) begin
            if (!stall) begin
                wb_valid_next     = 1'b1;
                wb_result_next    = mem_result;
                wb_waddr_next     = waddr_reg;
                wb_reg_write_next = reg_write_reg;
                wb_inst_next      = inst_reg;
                state_next        = ST_IDLE;
            end else begin
                buf_result_next = mem_result;
                state_next      = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            wstrb_reg        <= '0;
            wdata_reg        <= '0;
            wr_reg           <= 1'b0;
            waddr_reg        <= '0;
            reg_write_reg    <= 1'b0;
            mem_to_reg_reg   <= 1'b0;
            size_reg         <= '0;
            unsigned_reg     <= 1'b0;
            inst_reg         <= '0;
            buf_result_reg   <= '0;
            wb_valid_reg     <= 1'b0;
            wb_result_reg    <= '0;
            wb_waddr_reg     <= '0;
            wb_reg_write_reg <= 1'b0;
            wb_inst_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            wstrb_reg        <= wstrb_next;
            wdata_reg        <= wdata_next;
            wr_reg           <= wr_next;
            waddr_reg        <= waddr_next;
            reg_write_reg    <= reg_write_next;
            mem_to_reg_reg   <= mem_to_reg_next;
            size_reg         <= size_next;
            unsigned_reg     <= unsigned_next;
            inst_reg         <= inst_next;
            buf_result_reg   <= buf_result_next;
            wb_valid_reg     <= wb_valid_next;
            wb_result_reg    <= wb_result_next;
            wb_waddr_reg     <= wb_waddr_next;
            wb_reg_write_reg <= wb_reg_write_next;
            wb_inst_reg      <= wb_inst_next;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= misaligned_next;
        end
    end

    assign mem_misaligned = misaligned_reg;
`endif

    assign data_req     = (state_reg == ST_REQ);
    assign data_wr      = wr_reg;
    assign data_addr    = {addr_reg[31:2], 2'b00};
    assign data_wstrb   = wstrb_reg;
    assign data_wdata   = wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_result    = wb_result_reg;
    assign wb_waddr     = wb_waddr_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign wb_inst      = wb_inst_reg;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cases plus random ALU/load/store traffic against a
// behavioural lane model. Builds with or without MEM_ALIGN_CHECK_EN.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_waddr;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_load_unsigned;
    logic [31:0] ex_inst;
    logic        ex_ready;
    logic        stall_req;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_waddr;
    logic        wb_reg_write;
    logic [31:0] wb_inst;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_misaligned;
`endif

    int          tests = 0;
    int          fails = 0;
    int          op_id = 0;
    logic [31:0] last_wb = 32'd0;

    memory_access dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_waddr         (ex_waddr),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_size          (ex_size),
        .ex_load_unsigned (ex_load_unsigned),
        .ex_inst          (ex_inst),
        .ex_ready         (ex_ready),
        .stall_req        (stall_req),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_addr        (data_addr),
        .data_wstrb       (data_wstrb),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata),
        .wb_valid         (wb_valid),
        .wb_result        (wb_result),
        .wb_waddr         (wb_waddr),
        .wb_reg_write     (wb_reg_write),
`ifdef MEM_ALIGN_CHECK_EN
        .mem_misaligned   (mem_misaligned),
`endif
        .wb_inst          (wb_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference lane model: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * a[1])) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wstrb(input int sz, input logic [31:0] a);
        int s;
        if (sz == 0)      s = (1 << a[1:0]) & 15;
        else if (sz == 1) s = (3 << a[1:0]) & 15;
        else              s = 15;
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    // kind: 0 ALU, 1 load, 2 store. aok: REQ cycle (1-based) that sees addr_ok;
    // dok: cycles after addr_ok until data_ok (0 = same cycle).
    task automatic run_op(input int kind, input int sz, input bit uns, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd, input int aok,
                          input int dok, input bit stall_case, input logic [4:0] wa);
        bit          is_mem;
        bit          regw;
        bit          mis;
        bit          got_addr;
        bit          done;
        int          cnt;
        logic [31:0] inst;
        logic [31:0] exp_res;
        is_mem   = (kind != 0);
        regw     = (kind != 2);
        mis      = 1'b0;
        got_addr = 1'b0;
        done     = 1'b0;
        cnt      = 0;
        inst     = $urandom;
        exp_res  = addr;
        op_id++;

        @(negedge clk);
        ex_valid         = 1'b1;
        ex_alu_result    = addr;
        ex_store_data    = sd;
        ex_waddr         = wa;
        ex_reg_write     = regw;
        ex_mem_to_reg    = (kind == 1);
        ex_mem_read      = (kind == 1);
        ex_mem_write     = (kind == 2);
        ex_size          = 2'(sz);
        ex_load_unsigned = uns;
        ex_inst          = inst;
        #1;
        check("ex_ready_accept", 32'(ex_ready), 32'd1);
        check("stall_req_accept", 32'(stall_req), 32'(is_mem));
        @(negedge clk);
        ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = is_mem && (((sz == 1) && addr[0]) || ((sz == 2) && (addr[1:0] != 2'b00)));
`endif
        if (!is_mem || mis) begin
            #1;
            check("wb_valid_short", 32'(wb_valid), 32'd1);
            check("wb_result_short", wb_result, addr);
            check("wb_waddr_short", 32'(wb_waddr), 32'(wa));
            check("wb_reg_write_short", 32'(wb_reg_write), 32'(regw && !mis));
            check("wb_inst_short", wb_inst, inst);
            check("data_req_short", 32'(data_req), 32'd0);
            check("stall_req_short", 32'(stall_req), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            check("mem_misaligned", 32'(mem_misaligned), 32'(mis));
`endif
            last_wb = addr;
        end else begin
            if (kind == 1) exp_res = model_load(rd, addr, sz, uns);
            for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
                #1;
                if (!got_addr) begin
                    check("data_req_req", 32'(data_req), 32'd1);
                    if (cyc == 1) begin
                        check("data_addr", data_addr, addr & 32'hFFFF_FFFC);
                        check("data_wr", 32'(data_wr), 32'(kind == 2));
                        check("data_wstrb", 32'(data_wstrb), (kind == 2) ? model_wstrb(sz, addr) : 32'd0);
                        if (kind == 2) check("data_wdata", data_wdata, model_wdata(sz, sd));
                    end
                    if (cyc >= aok) begin
                        data_addr_ok = 1'b1;
                        got_addr     = 1'b1;
                        if (dok == 0) begin
                            data_data_ok = 1'b1;
                            data_rdata   = rd;
                            done         = 1'b1;
                        end
                    end
                end else begin
                    check("data_req_wait", 32'(data_req), 32'd0);
                    cnt++;
                    if (cnt >= dok) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rd;
                        done         = 1'b1;
                    end
                end
                check("stall_req_busy", 32'(stall_req), 32'd1);
                if (done) stall = stall_case;
                @(negedge clk);
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                data_rdata   = $urandom;
            end
            if (!done) check("handshake_timeout", 32'd0, 32'd1);
            if (stall_case) begin
                repeat (2) begin
                    #1;
                    check("wb_valid_hold", 32'(wb_valid), 32'd0);
                    check("wb_result_hold", wb_result, last_wb);
                    check("stall_req_hold", 32'(stall_req), 32'd1);
                    @(negedge clk);
                end
                stall = 1'b0;
                @(negedge clk);
            end
            #1;
            check("wb_valid_mem", 32'(wb_valid), 32'd1);
            check("wb_result_mem", wb_result, exp_res);
            check("wb_waddr_mem", 32'(wb_waddr), 32'(wa));
            check("wb_reg_write_mem", 32'(wb_reg_write), 32'(regw));
            check("wb_inst_mem", wb_inst, inst);
            check("stall_req_done", 32'(stall_req), 32'd0);
            last_wb = exp_res;
        end
        @(negedge clk);
        #1;
        check("wb_valid_pulse", 32'(wb_valid), 32'd0);
        check("wb_result_keep", wb_result, last_wb);
        $display("[TB] op %0d kind=%0d size=%0d addr=%08h stall=%0d wb_result=%08h", op_id, kind, sz,
                 addr, stall_case, wb_result);
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_waddr = '0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_size = '0; ex_load_unsigned = 1'b0; ex_inst = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_data_wstrb", 32'(data_wstrb), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ADD, LB sign-extend, SH lanes, LHU same-cycle ok, LW through HOLD
        run_op(0, 2, 1'b0, 32'h0000_0005, 32'd0, 32'd0, 1, 0, 1'b0, 5'd3);
        run_op(1, 0, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 1, 1, 1'b0, 5'd4);
        run_op(2, 1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1, 1, 1'b0, 5'd0);
        run_op(1, 1, 1'b1, 32'h0000_4002, 32'd0, 32'h8001_0000, 1, 0, 1'b0, 5'd7);
        run_op(1, 2, 1'b0, 32'h0000_5000, 32'd0, 32'hDEAD_BEEF, 2, 2, 1'b1, 5'd9);

        // Reset while a store sits in WAIT; the late data_ok must be ignored.
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = 32'h0000_3000; ex_store_data = 32'hCAFE_F00D;
        ex_mem_write = 1'b1; ex_mem_read = 1'b0; ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0;
        ex_size = 2'b10;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_write = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        check("wait_data_req", 32'(data_req), 32'd0);
        check("wait_wstrb", 32'(data_wstrb), 32'hF);
        check("wait_stall_req", 32'(stall_req), 32'd1);
        rstn = 1'b0;
        #1;
        check("arst_data_req", 32'(data_req), 32'd0);
        check("arst_ex_ready", 32'(ex_ready), 32'd1);
        check("arst_wb_result", wb_result, 32'd0);
        check("arst_wb_inst", wb_inst, 32'd0);
        check("arst_data_wstrb", 32'(data_wstrb), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("late_ok_wb_valid", 32'(wb_valid), 32'd0);
        check("late_ok_wb_result", wb_result, 32'd0);
        check("late_ok_stall_req", 32'(stall_req), 32'd0);
        $display("[TB] reset in WAIT, late data_ok dropped wb_valid=%0d", wb_valid);
        last_wb = 32'd0;

        // LW at an unaligned address: trapped with the macro, low bits ignored without.
        run_op(1, 2, 1'b0, 32'h0000_6001, 32'd0, 32'h0BAD_F00D, 1, 1, 1'b0, 5'd12);

        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data/address and 5-bit register index.
REQ-002 clk  in  1  single clock, all state updates on the rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  downstream hold; WB output register keeps its value while high.
REQ-005 ex_valid  in  1  EX stage presents an operation this cycle.
REQ-006 ex_alu_result  in  32  ALU result, or effective address for loads and stores.
REQ-007 ex_store_data  in  32  rt value for stores.
REQ-008 ex_waddr  in  5  destination register; ex_reg_write  in  1  write enable; ex_mem_to_reg  in  1  select load data.
REQ-009 ex_mem_read  in  1  load; ex_mem_write  in  1  store; ex_size  in  2  00 byte, 01 half, 10 word; ex_load_unsigned  in  1  zero-extend the load.
REQ-010 ex_inst  in  32  instruction word, passed through to WB.
REQ-011 ex_ready  out  1  operation accepted this cycle.
REQ-012 stall_req  out  1  request to freeze upstream stages.
REQ-013 data_req  out  1; data_wr  out  1; data_addr  out  32; data_wstrb  out  4; data_wdata  out  32; data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  32  data-SRAM handshake.
REQ-014 wb_valid  out  1; wb_result  out  32; wb_waddr  out  5; wb_reg_write  out  1; wb_inst  out  32  registered MEM/WB outputs.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, REQ, WAIT and HOLD.
REQ-016 ex_ready SHALL equal (state==IDLE && !stall); an operation is accepted when ex_valid && ex_ready.
REQ-017 An accepted non-memory operation SHALL appear on wb_* on the next edge (latency 1), with wb_result = ex_alu_result.
REQ-018 An accepted load or store SHALL latch all ex_* fields and move to REQ.
REQ-019 In REQ, data_req SHALL be 1 and addr/wr/wstrb/wdata SHALL be stable until data_addr_ok; on data_addr_ok the FSM SHALL move to WAIT.
REQ-020 In WAIT, on data_data_ok the FSM SHALL go to IDLE and write wb_* if !stall, otherwise buffer the result and go to HOLD.
REQ-021 If data_addr_ok and data_data_ok are both high in REQ, the FSM SHALL complete as in WAIT in the same cycle.
REQ-022 HOLD SHALL write the buffered result to wb_* on the first cycle with !stall, then return to IDLE.
REQ-023 data_addr SHALL be {addr[31:2],2'b00}. wstrb SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; loads 0000.
REQ-024 wdata SHALL replicate the byte x4 or the half x2; a word is passed unchanged.
REQ-025 Loads SHALL select the lane by addr[1:0] and sign- or zero-extend it per ex_load_unsigned.
REQ-026 stall_req SHALL be 1 whenever state!=IDLE, and in IDLE while ex_valid carries a memory op.
REQ-027 wb_valid SHALL pulse for one cycle per completed operation; with stall high it SHALL hold its value.

Reset
REQ-028 On rstn low, state SHALL go to IDLE and data_req SHALL be 0.
REQ-029 On rstn low, every wb_* output, data_wstrb and the internal buffer SHALL be 0; an in-flight access is abandoned.
REQ-030 A data_data_ok arriving in IDLE SHALL be ignored.

Configuration
REQ-031 Misalignment checking SHALL be controlled by the macro MEM_ALIGN_CHECK_EN.
REQ-032 With MEM_ALIGN_CHECK_EN defined, port mem_misaligned (out, 1) SHALL exist.
REQ-033 With the macro, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no data_req and SHALL complete in 1 cycle with wb_reg_write=0 and mem_misaligned=1 for that cycle.
REQ-034 Without the macro, the port SHALL be absent and low address bits SHALL be ignored for lane selection beyond REQ-023.

Structure
REQ-035 The shared defines header SHALL hold the size encodings, the FSM state encodings and the wstrb constants.
REQ-036 Lane selection and extension SHALL be implemented in sub-module load_align, which is purely combinational.

Verification
REQ-037 Add, result 0x00000005, waddr 3 -> next cycle wb_valid=1, wb_result=0x5, stall_req=0.
REQ-038 LB, addr 0x1003, rdata 0x80FF_FF_FF, addr_ok +1, data_ok +2 -> wb_result=0xFFFFFF80; stall_req high for 3 cycles.
REQ-039 SH, addr 0x2002, data 0x1234ABCD -> data_wstrb=1100, data_wdata=0xABCDABCD, data_wr=1.
REQ-040 LHU with addr_ok and data_ok in the same cycle, rdata 0x8001_0000, addr 0x..2 -> wb_result=0x00008001.
REQ-041 data_ok arrives while stall=1 -> HOLD; wb_* unchanged until stall drops, then the result appears once.
REQ-042 rstn pulsed low while in WAIT -> IDLE, data_req=0, a late data_ok is ignored; with MEM_ALIGN_CHECK_EN, LW at 0x..1 -> no data_req, mem_misaligned=1.
